// File: rtl/fft_avg_ctrl.sv
// Averaging FFT controller: captures one frame of ADC samples per trigger, streams it to the FFT core,
// and coherently accumulates NAVG complex spectra bin-by-bin into a host-readable spectrum RAM.
module fft_avg_ctrl #(
    parameter int DWIDTH         = 14,
    parameter int FFT_INWIDTH    = 18,
    parameter int FFT_OUTWIDTH   = 29,
    parameter int FFTPTS_WIDTH   = 11,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int RAM_DATA_WIDTH = 64,
    parameter int NAVG_WIDTH     = 8
) (
    input  logic                      in_clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [FFTPTS_WIDTH-1:0]   fftpts_in,
    input  logic [NAVG_WIDTH-1:0]     navg_in,
    input  logic                      frame_trig,
    input  logic [DWIDTH-1:0]         datain,
    input  logic                      din_valid,
    output logic [FFTPTS_WIDTH-1:0]   fft_pts,
    output logic                      fft_sink_valid,
    output logic                      fft_sink_sop,
    output logic                      fft_sink_eop,
    output logic [FFT_INWIDTH-1:0]    fft_sink_real,
    output logic [FFT_INWIDTH-1:0]    fft_sink_imag,
    input  logic                      fft_sink_ready,
    input  logic                      fft_src_valid,
    input  logic                      fft_src_sop,
    input  logic                      fft_src_eop,
    input  logic [FFT_OUTWIDTH-1:0]   fft_src_real,
    input  logic [FFT_OUTWIDTH-1:0]   fft_src_imag,
    output logic                      fft_src_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_rd_data,
    output logic                      busy,
    output logic                      done,
    output logic [NAVG_WIDTH-1:0]     frame_cnt,
    output logic                      err_overrun,
    output logic                      err_len,
    output logic                      err_sat
);
    localparam int AW = RAM_DATA_WIDTH / 2;
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_FILL, S_WAIT_OUT, S_ACCUM, S_DONE} state_t;

    // Returns {saturated, clamped sum} of two signed accumulator-width operands.
    function automatic logic [AW:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] sum;
        sum = {a[AW-1], a} + {b[AW-1], b};
        if (sum[AW] != sum[AW-1]) sat_add = {1'b1, (sum[AW] ? ACC_MIN : ACC_MAX)};
        else                      sat_add = {1'b0, sum[AW-1:0]};
    endfunction

    state_t                    state_q, state_d;
    logic [FFTPTS_WIDTH-1:0]   fft_pts_q, fft_pts_d, samp_cnt_q, samp_cnt_d, bin_q, bin_d;
    logic [NAVG_WIDTH-1:0]     navg_q, navg_d, frame_cnt_q, frame_cnt_d;
    logic                      sink_valid_q, sink_valid_d, sink_sop_q, sink_sop_d, sink_eop_q, sink_eop_d;
    logic [FFT_INWIDTH-1:0]    sink_real_q, sink_real_d;
    logic                      busy_q, busy_d, done_q, done_d;
    logic                      err_overrun_q, err_overrun_d, err_len_q, err_len_d, err_sat_q, err_sat_d;
    logic                      wr_en_q, wr_en_d, wr_add_q, wr_add_d;
    logic [RAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0]             wr_real_q, wr_real_d, wr_imag_q, wr_imag_d;
    logic [RAM_DATA_WIDTH-1:0] ram_rd_data_q;

    logic [RAM_DATA_WIDTH-1:0] spec_mem [2**RAM_ADDR_WIDTH];
    logic [RAM_DATA_WIDTH-1:0] acc_rd_word, wr_word;
    logic [AW:0]               sum_re, sum_im;
    logic [FFTPTS_WIDTH-1:0]   bin_addr, pts_last;
    logic [NAVG_WIDTH-1:0]     frame_cnt_inc;
    logic                      src_beat, last_bin;

    assign src_beat      = (state_q == S_ACCUM) && fft_src_valid;
    assign bin_addr      = fft_src_sop ? '0 : bin_q;
    assign pts_last      = fft_pts_q - 1'b1;
    assign last_bin      = (bin_addr == pts_last);
    assign frame_cnt_inc = frame_cnt_q + 1'b1;

    // Write stage: first frame stores the bin as-is, later frames add onto the word read last cycle.
    always_comb begin
        sum_re  = wr_add_q ? sat_add(acc_rd_word[AW-1:0], wr_real_q) : {1'b0, wr_real_q};
        sum_im  = wr_add_q ? sat_add(acc_rd_word[RAM_DATA_WIDTH-1:AW], wr_imag_q) : {1'b0, wr_imag_q};
        wr_word = {sum_im[AW-1:0], sum_re[AW-1:0]};
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case can infer a latch.
        state_d       = state_q;
        fft_pts_d     = fft_pts_q;
        navg_d        = navg_q;
        frame_cnt_d   = frame_cnt_q;
        samp_cnt_d    = samp_cnt_q;
        bin_d         = bin_q;
        sink_valid_d  = 1'b0;
        sink_sop_d    = 1'b0;
        sink_eop_d    = 1'b0;
        sink_real_d   = sink_real_q;
        err_overrun_d = err_overrun_q;
        err_len_d     = err_len_q;
        err_sat_d     = err_sat_q | (wr_en_q & (sum_re[AW] | sum_im[AW]));
        wr_en_d       = 1'b0;
        wr_add_d      = wr_add_q;
        wr_addr_d     = wr_addr_q;
        wr_real_d     = wr_real_q;
        wr_imag_d     = wr_imag_q;

        case (state_q)
            S_IDLE: if (start) begin
                fft_pts_d     = fftpts_in;
                navg_d        = (navg_in == '0) ? NAVG_WIDTH'(1) : navg_in;
                frame_cnt_d   = '0;
                err_overrun_d = 1'b0;
                err_len_d     = 1'b0;
                err_sat_d     = 1'b0;
                state_d       = S_ARM;
            end
            S_ARM: if (frame_trig) begin
                samp_cnt_d = '0;
                state_d    = S_FILL;
            end
            S_FILL: if (din_valid) begin
                if (fft_sink_ready) begin
                    sink_valid_d = 1'b1;
                    sink_sop_d   = (samp_cnt_q == '0);
                    sink_eop_d   = (samp_cnt_q == pts_last);
                    sink_real_d  = {{(FFT_INWIDTH-DWIDTH){datain[DWIDTH-1]}}, datain};
                    samp_cnt_d   = samp_cnt_q + 1'b1;
                    if (samp_cnt_q == pts_last) state_d = S_WAIT_OUT;
                end else begin
                    err_overrun_d = 1'b1;
                end
            end
            S_WAIT_OUT: if (fft_src_valid && fft_src_sop) state_d = S_ACCUM;
            S_ACCUM: if (fft_src_valid) begin
                wr_en_d   = 1'b1;
                wr_add_d  = (frame_cnt_q != '0);
                wr_addr_d = bin_addr[RAM_ADDR_WIDTH-1:0];
                wr_real_d = {{(AW-FFT_OUTWIDTH){fft_src_real[FFT_OUTWIDTH-1]}}, fft_src_real};
                wr_imag_d = {{(AW-FFT_OUTWIDTH){fft_src_imag[FFT_OUTWIDTH-1]}}, fft_src_imag};
                bin_d     = bin_addr + 1'b1;
                // A short or over-long frame is flagged but still closes and counts.
                if (fft_src_eop || last_bin) begin
                    err_len_d   = err_len_q | (fft_src_eop != last_bin);
                    frame_cnt_d = frame_cnt_inc;
                    state_d     = (frame_cnt_inc == navg_q) ? S_DONE : S_ARM;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fft_pts_q     <= '0;
            navg_q        <= '0;
            frame_cnt_q   <= '0;
            samp_cnt_q    <= '0;
            bin_q         <= '0;
            sink_valid_q  <= 1'b0;
            sink_sop_q    <= 1'b0;
            sink_eop_q    <= 1'b0;
            sink_real_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_overrun_q <= 1'b0;
            err_len_q     <= 1'b0;
            err_sat_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_add_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_real_q     <= '0;
            wr_imag_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
            state_q       <= state_d;
            fft_pts_q     <= fft_pts_d;
            navg_q        <= navg_d;
            frame_cnt_q   <= frame_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            bin_q         <= bin_d;
            sink_valid_q  <= sink_valid_d;
            sink_sop_q    <= sink_sop_d;
            sink_eop_q    <= sink_eop_d;
            sink_real_q   <= sink_real_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_overrun_q <= err_overrun_d;
            err_len_q     <= err_len_d;
            err_sat_q     <= err_sat_d;
            wr_en_q       <= wr_en_d;
            wr_add_q      <= wr_add_d;
            wr_addr_q     <= wr_addr_d;
            wr_real_q     <= wr_real_d;
            wr_imag_q     <= wr_imag_d;
        end
    end

    // NOTE: the spectrum array has no reset so it maps onto block RAM; its contents start undefined.
    always_ff @(posedge in_clk) begin
        if (src_beat) acc_rd_word <= spec_mem[bin_addr[RAM_ADDR_WIDTH-1:0]];
        if (wr_en_q)  spec_mem[wr_addr_q] <= wr_word;
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) ram_rd_data_q <= '0;
        else        ram_rd_data_q <= spec_mem[ram_rd_addr];
    end

    assign fft_pts        = fft_pts_q;
    assign fft_sink_valid = sink_valid_q;
    assign fft_sink_sop   = sink_sop_q;
    assign fft_sink_eop   = sink_eop_q;
    assign fft_sink_real  = sink_real_q;
    assign fft_sink_imag  = '0;
    assign fft_src_ready  = (state_q == S_ACCUM);
    assign ram_rd_data    = ram_rd_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign frame_cnt      = frame_cnt_q;
    assign err_overrun    = err_overrun_q;
    assign err_len        = err_len_q;
    assign err_sat        = err_sat_q;
endmodule

// File: tb/tb_fft_avg_ctrl.sv
// Bench for fft_avg_ctrl: a table of averaging runs driven through a stand-in FFT (bin k = 8*x[k] - j*3*x[k]),
// plus hand sequences for reset mid-run and start-while-busy.
module tb_fft_avg_ctrl;
    localparam int DWIDTH         = 14;
    localparam int FFT_INWIDTH    = 18;
    localparam int FFT_OUTWIDTH   = 29;
    localparam int FFTPTS_WIDTH   = 11;
    localparam int RAM_ADDR_WIDTH = 10;
    localparam int RAM_DATA_WIDTH = 64;
    localparam int NAVG_WIDTH     = 8;

    logic                      in_clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start = 1'b0;
    logic [FFTPTS_WIDTH-1:0]   fftpts_in = '0;
    logic [NAVG_WIDTH-1:0]     navg_in = '0;
    logic                      frame_trig = 1'b0;
    logic [DWIDTH-1:0]         datain = '0;
    logic                      din_valid = 1'b0;
    logic [FFTPTS_WIDTH-1:0]   fft_pts;
    logic                      fft_sink_valid, fft_sink_sop, fft_sink_eop;
    logic [FFT_INWIDTH-1:0]    fft_sink_real, fft_sink_imag;
    logic                      fft_sink_ready = 1'b1;
    logic                      fft_src_valid = 1'b0, fft_src_sop = 1'b0, fft_src_eop = 1'b0;
    logic [FFT_OUTWIDTH-1:0]   fft_src_real = '0, fft_src_imag = '0;
    logic                      fft_src_ready;
    logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr = '0;
    logic [RAM_DATA_WIDTH-1:0] ram_rd_data;
    logic                      busy, done;
    logic [NAVG_WIDTH-1:0]     frame_cnt;
    logic                      err_overrun, err_len, err_sat;

    fft_avg_ctrl dut (
        .in_clk(in_clk), .rst_n(rst_n), .start(start), .fftpts_in(fftpts_in), .navg_in(navg_in),
        .frame_trig(frame_trig), .datain(datain), .din_valid(din_valid), .fft_pts(fft_pts),
        .fft_sink_valid(fft_sink_valid), .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
        .fft_sink_real(fft_sink_real), .fft_sink_imag(fft_sink_imag), .fft_sink_ready(fft_sink_ready),
        .fft_src_valid(fft_src_valid), .fft_src_sop(fft_src_sop), .fft_src_eop(fft_src_eop),
        .fft_src_real(fft_src_real), .fft_src_imag(fft_src_imag), .fft_src_ready(fft_src_ready),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .busy(busy), .done(done),
        .frame_cnt(frame_cnt), .err_overrun(err_overrun), .err_len(err_len), .err_sat(err_sat)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        int pts; int navg; int mode; int stall; int eop_at; int ram_bins;
        int exp_frames; bit exp_ovr; bit exp_len; bit exp_sat;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int sine_tab [1024];
    int cap [1024];
    int cap_beats, cap_sop, cap_eop, cap_bad;
    vec_t vecs [6];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sample sources: 0 DC, 1 sine, otherwise a signed ramp covering the full ADC range.
    function automatic int sample(input int mode, input int n);
        if (mode == 0)      return 100;
        else if (mode == 1) return sine_tab[n % 1024];
        else                return ((n * 37) % 16384) - 8192;
    endfunction

    // Mode 3 makes the stand-in FFT emit constant full-scale bins.
    function automatic int bin_val(input int mode, input int k, input bit im);
        if (mode == 3) return im ? -(1 << 28) : (1 << 28) - 1;
        return im ? -3 * cap[k] : 8 * cap[k];
    endfunction

    function automatic longint exp_acc(input int mode, input int k, input int navg, input bit im);
        longint per, v;
        if (mode == 3) per = im ? -(longint'(1) << 28) : (longint'(1) << 28) - 1;
        else           per = longint'(im ? -3 : 8) * longint'(sample(mode, k));
        v = longint'(navg) * per;
        if (v > 64'sd2147483647)  v = 64'sd2147483647;
        if (v < -64'sd2147483648) v = -64'sd2147483648;
        return v;
    endfunction

    task automatic grab_sink(input int mode);
        int v;
        if (fft_sink_valid) begin
            v = int'(signed'(fft_sink_real));
            if (cap_beats < 1024) cap[cap_beats] = v;
            if (fft_sink_sop) cap_sop = cap_beats;
            if (fft_sink_eop) cap_eop = cap_beats;
            if (v != sample(mode, cap_beats) || fft_sink_imag != '0) cap_bad++;
            cap_beats++;
        end
    endtask

    task automatic do_start(input int pts, input int navg);
        @(posedge in_clk); #1;
        start = 1'b1; fftpts_in = FFTPTS_WIDTH'(pts); navg_in = NAVG_WIDTH'(navg);
        @(posedge in_clk); #1;
        start = 1'b0;
    endtask

    // Trigger a frame and feed n samples; ready drops for stall_len cycles halfway through.
    task automatic fill_frame(input int n, input int mode, input int stall_len);
        int acc, cyc, stall_left;
        bit rdy;
        acc = 0; cyc = 0; stall_left = stall_len;
        cap_beats = 0; cap_sop = -1; cap_eop = -1; cap_bad = 0;
        @(posedge in_clk); #1 frame_trig = 1'b1;
        @(posedge in_clk); #1 frame_trig = 1'b0;
        while (acc < n && cyc < 4 * n) begin
            din_valid = 1'b1;
            datain    = DWIDTH'(sample(mode, acc));
            if (acc == n / 2 && stall_left > 0) begin
                fft_sink_ready = 1'b0; stall_left--;
            end else begin
                fft_sink_ready = 1'b1;
            end
            rdy = fft_sink_ready;
            @(negedge in_clk); grab_sink(mode);
            @(posedge in_clk); #1;
            if (rdy) acc++;
            cyc++;
        end
        din_valid = 1'b0; fft_sink_ready = 1'b1;
        @(negedge in_clk); grab_sink(mode);
        check("fill_bound", acc, n);
    endtask

    // Stand-in FFT source: holds each beat until the controller accepts it.
    task automatic send_bins(input int n, input int mode, input int eop_at);
        int idx, guard;
        idx = 0; guard = 0;
        while (idx < n && guard < n + 50) begin
            @(posedge in_clk); #1;
            fft_src_valid = 1'b1;
            fft_src_sop   = (idx == 0);
            fft_src_eop   = (idx == eop_at);
            fft_src_real  = FFT_OUTWIDTH'(bin_val(mode, idx, 1'b0));
            fft_src_imag  = FFT_OUTWIDTH'(bin_val(mode, idx, 1'b1));
            @(negedge in_clk);
            if (fft_src_ready) idx++;
            guard++;
        end
        @(posedge in_clk); #1;
        fft_src_valid = 1'b0; fft_src_sop = 1'b0; fft_src_eop = 1'b0;
        check("src_accept_bound", idx, n);
    endtask

    task automatic wait_done();
        int seen;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge in_clk);
            if (done) seen++;
        end
        check("done_pulse_cycles", seen, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_ram(input int n, input int mode, input int navg);
        int bad;
        longint re, im;
        bad = 0;
        for (int k = 0; k <= n; k++) begin
            @(posedge in_clk); #1;
            if (k < n) ram_rd_addr = RAM_ADDR_WIDTH'(k);
            @(negedge in_clk);
            if (k > 0) begin
                re = longint'(signed'(ram_rd_data[31:0]));
                im = longint'(signed'(ram_rd_data[63:32]));
                if (k == 1) begin
                    check("ram_bin0_real", re, exp_acc(mode, 0, navg, 1'b0));
                    check("ram_bin0_imag", im, exp_acc(mode, 0, navg, 1'b1));
                end
                if (re != exp_acc(mode, k - 1, navg, 1'b0) || im != exp_acc(mode, k - 1, navg, 1'b1)) bad++;
            end
        end
        check("ram_bad_bins", bad, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int navg_eff, nb, smode;
        navg_eff = (v.navg == 0) ? 1 : v.navg;
        smode    = (v.mode == 3) ? 2 : v.mode;
        do_start(v.pts, v.navg);
        @(negedge in_clk);
        check("fft_pts_latched", fft_pts, v.pts);
        for (int f = 0; f < navg_eff; f++) begin
            fill_frame(v.pts, smode, (f == 0) ? v.stall : 0);
            if (f == 0) begin
                check("sink_beats", cap_beats, v.pts);
                check("sink_sop_beat", cap_sop, 0);
                check("sink_eop_beat", cap_eop, v.pts - 1);
                check("sink_data_bad", cap_bad, 0);
            end
            nb = (f == 0 && v.eop_at >= 0) ? v.eop_at + 1 : v.pts;
            send_bins(nb, v.mode, nb - 1);
            if (f != navg_eff - 1 && f < 3) begin
                @(negedge in_clk);
                check("frame_cnt_mid", frame_cnt, f + 1);
                check("busy_mid", busy, 1);
            end
        end
        wait_done();
        check("frame_cnt_final", frame_cnt, v.exp_frames);
        check("err_overrun", err_overrun, v.exp_ovr);
        check("err_len", err_len, v.exp_len);
        check("err_sat", err_sat, v.exp_sat);
        if (v.ram_bins > 0) check_ram(v.ram_bins, v.mode, navg_eff);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) sine_tab[i] = int'(8000.0 * $sin(2.0 * 3.14159265358979 * 0.01 * i));
        //            pts  navg mode stall eop_at bins frames ovr len sat
        vecs[0] = '{1024,   1,   0,   0,   -1, 1024,   1,   0,  0,  0};
        vecs[1] = '{1024,   4,   1,   0,   -1, 1024,   4,   0,  0,  0};
        vecs[2] = '{1024,   1,   2,   3,   -1, 1024,   1,   1,  0,  0};
        vecs[3] = '{  64, 255,   3,   0,   -1,   64, 255,   0,  0,  1};
        vecs[4] = '{1024,   2,   2,   0,  500,  501,   2,   0,  1,  0};
        vecs[5] = '{  64,   0,   2,   0,   -1,   64,   1,   0,  0,  0};

        repeat (3) @(posedge in_clk);
        @(negedge in_clk);
        check("reset_ctrl_outs", {busy, done, fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_src_ready}, 0);
        check("reset_flags", {err_overrun, err_len, err_sat}, 0);
        check("reset_fft_pts", fft_pts, 0);
        check("reset_frame_cnt", frame_cnt, 0);
        check("reset_ram_rd_data", ram_rd_data, 0);
        @(posedge in_clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // start while busy must not disturb the latched length
        do_start(64, 1);
        do_start(128, 3);
        @(negedge in_clk);
        check("start_busy_fft_pts", fft_pts, 64);
        fill_frame(64, 2, 0);
        send_bins(64, 2, 63);
        wait_done();
        check("start_busy_frames", frame_cnt, 1);

        // asynchronous reset in the middle of the second frame's capture
        do_start(64, 2);
        fill_frame(64, 2, 0);
        send_bins(64, 2, 63);
        @(negedge in_clk);
        check("pre_reset_frame_cnt", frame_cnt, 1);
        @(posedge in_clk); #1 frame_trig = 1'b1;
        @(posedge in_clk); #1 frame_trig = 1'b0;
        din_valid = 1'b1; datain = DWIDTH'(5); fft_sink_ready = 1'b0;
        repeat (2) @(posedge in_clk);
        #1 fft_sink_ready = 1'b1;
        repeat (4) @(posedge in_clk);
        @(negedge in_clk);
        check("pre_reset_overrun", err_overrun, 1);
        check("pre_reset_sink_valid", fft_sink_valid, 1);
        rst_n = 1'b0;
        @(negedge in_clk);
        check("rst_busy", busy, 0);
        check("rst_sink_valid", fft_sink_valid, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_flags", {err_overrun, err_len, err_sat, done}, 0);
        din_valid = 1'b0;
        @(posedge in_clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge in_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
